// File: rtl/adxl355_pkg.sv
// Shared constants and FSM state type for the ADXL355 transaction scheduler.
package adxl355_pkg;

  localparam logic [7:0] CMD_READ_ID   = 8'h01;
  localparam logic [7:0] CMD_READ_XYZ  = 8'h11;
  localparam logic [7:0] CMD_READ_FIFO = 8'h23;
  localparam logic [3:0] LEN_FIFO      = 4'd10;
  localparam int         GUARD_PAD     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/adxl355_seq_tick.sv
// Sample-rate divider: free-running counter, 1-clk wrap pulse every CLK_HZ/RATE_HZ clk.
// Wrap is combinational on the terminal count; no backpressure, never stalls.
module adxl355_seq_tick #(
  parameter int CLK_HZ  = 40000000,
  parameter int RATE_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);

  localparam int PERIOD = CLK_HZ / RATE_HZ;
  localparam int W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adxl355_seq.sv
// ADXL355 scheduler: periodic FIFO reads vs one-shot host commands, owns BRAM ring wraddr; sync 2 clk after a tick.
// Syncs are held off by direct access and until the first tick; ADXL355_SEQ_WATCHDOG_EN adds the stall port.
module adxl355_seq
  import adxl355_pkg::*;
#(
  parameter int CLK_HZ    = 40000000,
  parameter int RATE_HZ   = 1000,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 enable,
  input  logic                 direct_req,
  input  logic                 direct_en,
  input  logic                 host_req,
  input  logic [7:0]           host_cmd,
  input  logic [3:0]           host_len,
  output logic                 host_ack,
  output logic                 sync,
  output logic [7:0]           cmd,
  output logic [3:0]           len,
  input  logic                 wr16,
  output logic [ADDR_BITS-1:0] wraddr,
  input  logic [ADDR_BITS-1:0] rdaddr,
  output logic                 half,
  output logic                 overrun,
  output logic [7:0]           missed,
`ifdef ADXL355_SEQ_WATCHDOG_EN
  output logic                 stall,
`endif
  output logic                 direct_req_q
);

  seq_state_t state, state_nx;

  logic                 wrap, armed, blocked;
  logic                 tick_pend, host_pend, cur_host;
  logic                 go_tick, go_host, done, wake;
  logic                 clr_tick, drop_wrap, drop_blk;
  logic [8:0]           missed_sum;
  logic [7:0]           host_cmd_q, guard;
  logic [3:0]           host_len_q;
  logic [ADDR_BITS-1:0] wr_next;

  adxl355_seq_tick #(.CLK_HZ(CLK_HZ), .RATE_HZ(RATE_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .wrap (wrap)
  );

  assign blocked = direct_req | direct_en;
  assign go_tick = (state == IDLE) & armed & ~blocked & tick_pend;
  assign go_host = (state == IDLE) & armed & ~blocked & ~tick_pend & host_pend;

  // A wrap landing on the clearing cycle keeps the new tick; only a tick left waiting counts as dropped.
  assign clr_tick   = ((state == IDLE) & blocked) | ((state == SYNC) & ~cur_host);
  assign drop_wrap  = wrap & enable & tick_pend & ~clr_tick;
  assign drop_blk   = (state == IDLE) & blocked & tick_pend;
  assign missed_sum = {1'b0, missed} + {8'd0, drop_wrap} + {8'd0, drop_blk};

  always_comb begin
    state_nx = state;
    sync     = 1'b0;
    done     = 1'b0;
    host_ack = 1'b0;
    case (state)
      IDLE: if (go_tick || go_host) state_nx = SYNC;
      SYNC: begin
        sync     = 1'b1;
        state_nx = RUN;
      end
      RUN: if (clk_en && guard == 8'd1) begin
        done     = 1'b1;
        host_ack = cur_host | wake;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      tick_pend    <= 1'b0;
      host_pend    <= 1'b0;
      cur_host     <= 1'b0;
      host_cmd_q   <= 8'h00;
      host_len_q   <= 4'd2;
      cmd          <= CMD_READ_FIFO;
      len          <= LEN_FIFO;
      guard        <= 8'd0;
      missed       <= 8'd0;
      direct_req_q <= 1'b0;
    end else begin
      state <= state_nx;
      // The reader may still be finishing a pre-reset sequence; hold off until a full period has passed.
      if (wrap) armed <= 1'b1;

      if (wrap && enable) tick_pend <= 1'b1;
      else if (clr_tick)  tick_pend <= 1'b0;
      missed <= missed_sum[8] ? 8'hFF : missed_sum[7:0];

      if (host_req) begin
        host_pend  <= 1'b1;
        host_cmd_q <= host_cmd;
        host_len_q <= (host_len < 4'd2) ? 4'd2 : host_len;
      end else if (state == SYNC && cur_host) begin
        host_pend <= 1'b0;
      end

      if (state == IDLE) direct_req_q <= direct_req;
      if (go_tick) begin
        cmd      <= CMD_READ_FIFO;
        len      <= LEN_FIFO;
        cur_host <= 1'b0;
      end else if (go_host) begin
        cmd      <= host_cmd_q;
        len      <= host_len_q;
        cur_host <= 1'b1;
      end

      if (state == SYNC)                guard <= {len, 4'd0} + 8'(GUARD_PAD);
      else if (state == RUN && clk_en)  guard <= guard - 8'd1;
    end
  end

  assign wr_next = wraddr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wraddr  <= '0;
      half    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      half <= wr16 & (&wraddr[ADDR_BITS-2:0]);
      if (wr16) wraddr <= wr_next;
      if (wr16 && wr_next == rdaddr)          overrun <= 1'b1;
      else if (host_req && host_cmd == 8'h00) overrun <= 1'b0;
    end
  end

`ifdef ADXL355_SEQ_WATCHDOG_EN
  logic       wr_seen;
  logic [1:0] stall_run;

  // Fourth consecutive empty periodic read wakes the CPU through host_ack.
  assign wake = done & ~cur_host & ~wr_seen & (stall_run == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_seen   <= 1'b0;
      stall_run <= 2'd0;
      stall     <= 1'b0;
    end else begin
      if (state == SYNC)             wr_seen <= 1'b0;
      else if (state == RUN && wr16) wr_seen <= 1'b1;
      if (done && !cur_host) begin
        if (wr_seen) begin
          stall_run <= 2'd0;
        end else begin
          stall     <= 1'b1;
          stall_run <= stall_run + 2'd1;
        end
      end
    end
  end
`else
  assign wake = 1'b0;
`endif

endmodule

// File: tb/tb_adxl355_seq.sv
// Directed bench for adxl355_seq: reset state, ring/overrun/half, periodic and host syncs, guard timing, direct hold-off.
module tb_adxl355_seq;

  // Period long enough for a full 168-strobe FIFO read at half-rate clk_en plus a host read.
  localparam int CLK_HZ  = 1000;
  localparam int RATE_HZ = 2;
  localparam int AB      = 4;
  localparam int PERIOD  = CLK_HZ / RATE_HZ;

  logic          clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic          enable = 1'b0, direct_req = 1'b0, direct_en = 1'b0, host_req = 1'b0;
  logic [7:0]    host_cmd = 8'h00;
  logic [3:0]    host_len = 4'd0;
  logic          host_ack, sync, half, overrun, direct_req_q;
  logic [7:0]    cmd, missed;
  logic [3:0]    len;
  logic          wr16 = 1'b0;
  logic [AB-1:0] wraddr;
  logic [AB-1:0] rdaddr = '0;
`ifdef ADXL355_SEQ_WATCHDOG_EN
  logic          stall;
`endif

  adxl355_seq #(.CLK_HZ(CLK_HZ), .RATE_HZ(RATE_HZ), .ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .enable      (enable),
    .direct_req  (direct_req),
    .direct_en   (direct_en),
    .host_req    (host_req),
    .host_cmd    (host_cmd),
    .host_len    (host_len),
    .host_ack    (host_ack),
    .sync        (sync),
    .cmd         (cmd),
    .len         (len),
    .wr16        (wr16),
    .wraddr      (wraddr),
    .rdaddr      (rdaddr),
    .half        (half),
    .overrun     (overrun),
    .missed      (missed),
`ifdef ADXL355_SEQ_WATCHDOG_EN
    .stall       (stall),
`endif
    .direct_req_q(direct_req_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    clk_en = ~clk_en;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: sync/ack/half events and clk_en strobes counted since the last sync.
  int         cyc = 0, ce_cnt = 0, run_ce = 0, ack_ce = 0;
  int         n_sync = 0, n_ack = 0, n_half = 0, sync_cyc = 0;
  logic [7:0] sync_cmd = 8'h00;
  logic [3:0] sync_len = 4'd0;
  int         half_at[2];

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc++;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sync) begin
        n_sync++;
        sync_cyc = cyc;
        sync_cmd = cmd;
        sync_len = len;
        run_ce   = ce_cnt;
        ce_cnt   = 0;
      end else if (clk_en) begin
        ce_cnt++;
      end
      if (host_ack) begin
        n_ack++;
        ack_ce = ce_cnt;
      end
      if (half) begin
        if (n_half < 2) half_at[n_half] = int'(wraddr);
        n_half++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sync(input int budget, input string tag);
    int start = n_sync;
    int k = 0;
    while (n_sync == start && k < budget) begin
      step();
      k++;
    end
    if (n_sync == start) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int start = n_ack;
    int k = 0;
    while (n_ack == start && k < budget) begin
      step();
      k++;
    end
    if (n_ack == start) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_wr();
    wr16 = 1'b1;
    step();
    wr16 = 1'b0;
    step();
    step();
  endtask

  task automatic host_pulse(input logic [7:0] c, input logic [3:0] l);
    host_cmd = c;
    host_len = l;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
  endtask

  int s1, base;

  initial begin
    enable = 1'b1;
    rdaddr = 4'd3;
    repeat (3) step();
    chk("rst_sync",     sync,         0);
    chk("rst_host_ack", host_ack,     0);
    chk("rst_cmd",      cmd,          8'h23);
    chk("rst_len",      len,          10);
    chk("rst_wraddr",   wraddr,       0);
    chk("rst_half",     half,         0);
    chk("rst_overrun",  overrun,      0);
    chk("rst_missed",   missed,       0);
    chk("rst_dreq_q",   direct_req_q, 0);
    rst_n = 1'b1;

    // Ring: overrun when wraddr+1 hits rdaddr=3, then 13 more writes wrap 15->0.
    pulse_wr();
    pulse_wr();
    chk("ovr_before", overrun, 0);
    pulse_wr();
    chk("ovr_set",    overrun, 1);
    chk("ovr_wraddr", wraddr,  3);
    repeat (13) pulse_wr();
    chk("ring_wrap",   wraddr,     0);
    chk("half_count",  n_half,     2);
    chk("half_first",  half_at[0], 8);
    chk("half_second", half_at[1], 0);

    // Clear-overrun host command (len 0 coerced to 2) waits behind the first periodic read.
    host_pulse(8'h00, 4'd0);
    chk("ovr_clear", overrun, 0);
    chk("no_sync_before_tick", n_sync, 0);

    wait_sync(PERIOD + 20, "s1");
    s1 = sync_cyc;
    chk("s1_full_period", (sync_cyc >= PERIOD) ? 1 : 0, 1);
    chk("s1_cmd", sync_cmd, 8'h23);
    chk("s1_len", sync_len, 10);

    wait_sync(400, "h1");
    chk("h1_cmd",    sync_cmd, 8'h00);
    chk("h1_len",    sync_len, 2);
    chk("h1_follow", run_ce,   168);
    wait_ack(200, "h1_ack");
    chk("h1_guard",  ack_ce,   40);

    wait_sync(PERIOD + 20, "s2");
    chk("s2_interval", sync_cyc - s1, PERIOD);
    chk("s2_cmd",      sync_cmd,      8'h23);
    repeat (20) step();
    host_pulse(CMD_READ_ID_TB(), 4'd2);
    wait_sync(400, "h2");
    chk("h2_cmd",    sync_cmd, 8'h01);
    chk("h2_len",    sync_len, 2);
    chk("h2_follow", run_ce,   168);
    wait_ack(200, "h2_ack");
    chk("h2_guard",  ack_ce,   40);

    wait_sync(PERIOD + 20, "s3");
    chk("s3_interval", sync_cyc - s1, 2 * PERIOD);
    chk("s3_missed",   missed,        0);
    chk("ack_count",   n_ack,         2);

    // Direct access across exactly five tick wraps.
    repeat (400) step();
    direct_req = 1'b1;
    base = n_sync;
    repeat (2200) step();
    chk("dir_missed",  missed,        5);
    chk("dir_dreq_q",  direct_req_q,  1);
    chk("dir_no_sync", n_sync - base, 0);
    direct_req = 1'b0;
    wait_sync(PERIOD + 10, "s_after_dir");
    chk("after_dir_on_tick", (sync_cyc - s1) % PERIOD, 0);
    chk("after_dir_cmd",     sync_cmd,                 8'h23);
    chk("after_dir_dreq_q",  direct_req_q,             0);
`ifdef ADXL355_SEQ_WATCHDOG_EN
    chk("wd_stall", stall, 1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  function automatic logic [7:0] CMD_READ_ID_TB();
    return 8'h01;
  endfunction

endmodule
